// File: rtl/ser_pkg.sv
// Shared types and constants for the bit serializer front end.
// States cover the optional parity cycle; PAR is only ever entered when the
// design is built with SER_PARITY_EN.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } ser_state_e;

  // Parity sense selectors for the PAR_ODD parameter.
  localparam bit PAR_SENSE_EVEN = 1'b0;
  localparam bit PAR_SENSE_ODD  = 1'b1;

endpackage

// File: rtl/bit_serializer_if.sv
// Word-in / bit-out bus of the bit serializer.
// master: upstream word source plus serial-stream observer; slave: the serializer.
interface bit_serializer_if #(
  parameter int W = 8
);
  import ser_pkg::*;

  logic [W-1:0] data_in;
  logic         data_valid;
  logic         data_ready;
  logic         dout;
  logic         dout_valid;
  logic         sof;
  logic         busy;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  dout,
    input  dout_valid,
    input  sof,
    input  busy
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output dout,
    output dout_valid,
    output sof,
    output busy
  );

endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end feeding the 1101 sequence detector.
// Accepts W-bit words on valid/ready and emits one registered bit per clk.
// Back-to-back words stream without an idle gap so cross-word patterns survive.
// Optional build macro: SER_PARITY_EN adds one parity bit (sense PAR_ODD) per word.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PAR_ODD   = PAR_SENSE_EVEN
) (
  input logic              clk,
  input logic              clr,
  bit_serializer_if.slave  bus
);

  localparam int             CNT_W    = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ser_state_e       state_r, state_s;
  logic [W-1:0]     shift_r, shift_s;
  logic [CNT_W-1:0] bit_cnt_r, bit_cnt_s;
  logic             dout_r, dout_s;
  logic             dout_valid_r, dout_valid_s;
  logic             sof_r, sof_s;
  logic             data_ready_s;
  logic             accept_s;

`ifdef SER_PARITY_EN
  logic             par_r, par_s;

  // Parity bit sent after the payload: XOR of the word, inverted for odd sense.
  function automatic logic word_parity(input logic [W-1:0] w);
    return (^w) ^ PAR_ODD;
  endfunction
`else
  logic             unused_par_odd_s;
  assign unused_par_odd_s = PAR_ODD;
`endif

  // Bit that leaves the word first given the configured bit order.
  function automatic logic first_bit(input logic [W-1:0] w);
    if (MSB_FIRST) begin
      return w[W-1];
    end else begin
      return w[0];
    end
  endfunction

  // Move the next bit to the output end; rotation keeps every register bit live.
  function automatic logic [W-1:0] shift_once(input logic [W-1:0] w);
    if (MSB_FIRST) begin
      return {w[W-2:0], w[W-1]};
    end else begin
      return {w[0], w[W-1:1]};
    end
  endfunction

  // Ready is open in IDLE and in the final serial cycle of a word.
  always_comb begin
    data_ready_s = 1'b0;
    case (state_r)
      IDLE: begin
        data_ready_s = 1'b1;
      end
      SHIFT: begin
`ifdef SER_PARITY_EN
        data_ready_s = 1'b0;
`else
        data_ready_s = (bit_cnt_r == CNT_ZERO);
`endif
      end
      PAR: begin
`ifdef SER_PARITY_EN
        data_ready_s = 1'b1;
`else
        data_ready_s = 1'b0;
`endif
      end
      default: begin
        data_ready_s = 1'b0;
      end
    endcase
  end

  assign accept_s = bus.data_valid && data_ready_s;

  // Next-state and next-output logic; idle defaults drive zeros toward the detector.
  always_comb begin
    state_s      = state_r;
    shift_s      = shift_r;
    bit_cnt_s    = bit_cnt_r;
    dout_s       = 1'b0;
    dout_valid_s = 1'b0;
    sof_s        = 1'b0;
`ifdef SER_PARITY_EN
    par_s        = par_r;
`endif
    if (accept_s) begin
      state_s      = SHIFT;
      shift_s      = bus.data_in;
      bit_cnt_s    = CNT_LAST;
      dout_s       = first_bit(bus.data_in);
      dout_valid_s = 1'b1;
      sof_s        = 1'b1;
`ifdef SER_PARITY_EN
      par_s        = word_parity(bus.data_in);
`endif
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        SHIFT: begin
          if (bit_cnt_r != CNT_ZERO) begin
            shift_s      = shift_once(shift_r);
            bit_cnt_s    = bit_cnt_r - CNT_ONE;
            dout_s       = first_bit(shift_once(shift_r));
            dout_valid_s = 1'b1;
          end else begin
`ifdef SER_PARITY_EN
            state_s      = PAR;
            dout_s       = par_r;
            dout_valid_s = 1'b1;
`else
            state_s      = IDLE;
`endif
          end
        end
        PAR: begin
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; clr wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r      <= IDLE;
      shift_r      <= {W{1'b0}};
      bit_cnt_r    <= CNT_ZERO;
      dout_r       <= 1'b0;
      dout_valid_r <= 1'b0;
      sof_r        <= 1'b0;
`ifdef SER_PARITY_EN
      par_r        <= 1'b0;
`endif
    end else begin
      state_r      <= state_s;
      shift_r      <= shift_s;
      bit_cnt_r    <= bit_cnt_s;
      dout_r       <= dout_s;
      dout_valid_r <= dout_valid_s;
      sof_r        <= sof_s;
`ifdef SER_PARITY_EN
      par_r        <= par_s;
`endif
    end
  end

  assign bus.data_ready = data_ready_s;
  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.sof        = sof_r;
  assign bus.busy       = (state_r != IDLE);

endmodule
